// File: rtl/adbg_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the target-memory FSM state type.
package adbg_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    TGT_IDLE = 2'd0,
    TGT_WAIT = 2'd1,
    TGT_ERR1 = 2'd2,
    TGT_ERR2 = 2'd3
  } tgt_state_e;

endpackage

// File: rtl/adbg_ahb3_tgt_ram.sv
// Single-port word array with per-byte write enables and asynchronous read.
module adbg_ahb3_tgt_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic [NB-1:0]         we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // byte-lane write; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/adbg_ahb3_tgt_mem.sv
// AHB3-Lite target with word-addressed RAM, programmable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned beats.
module adbg_ahb3_tgt_mem
  import adbg_ahb3_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [1:0]            htrans_i,
  input  logic [2:0]            hburst_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hreadyout_o,
  output logic                  hresp_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  function automatic logic is_illegal(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [2:0] size);
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] amask;
    idx   = addr >> BB;
    amask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    return (idx >= ADDR_WIDTH'(DEPTH)) || (size > 3'(BB)) ||
           ((addr & amask) != {ADDR_WIDTH{1'b0}});
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [BB-1:0] off,
                                              input logic [2:0] size);
    logic [NB-1:0] m;
    int lo;
    int n;
    lo = int'(off);
    n  = 32'sd1 << size;
    for (int b = 0; b < NB; b++) begin
      m[b] = (b >= lo) && (b < lo + n);
    end
    return m;
  endfunction

  tgt_state_e            state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [BB+AW-1:0]      addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  accept_s, illegal_s, load_s, done_s;
  tgt_state_e            load_state_s;
  logic [3:0]            load_wcnt_s;
  logic [NB-1:0]         we_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_s;

  assign unused_s     = ^{hburst_i, htrans_i[0]};
  assign accept_s     = hsel_i & hready_i & htrans_i[1];
  assign illegal_s    = is_illegal(haddr_i, hsize_i);
  assign done_s       = (state_q == TGT_WAIT) && (wcnt_q == 4'd0);
  assign load_state_s = illegal_s ? TGT_ERR1 : TGT_WAIT;
  assign load_wcnt_s  = illegal_s ? 4'd0 : 4'(WAIT_STATES);

  // next-state: a new beat may only be taken in a cycle where HREADYOUT is high
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    load_s  = 1'b0;
    case (state_q)
      TGT_IDLE: load_s = accept_s;
      TGT_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          load_s  = accept_s;
          state_d = TGT_IDLE;
        end
      end
      TGT_ERR1: state_d = TGT_ERR2;
      TGT_ERR2: begin
        load_s  = accept_s;
        state_d = TGT_IDLE;
      end
      default: state_d = TGT_IDLE;
    endcase
    if (load_s) begin
      state_d = load_state_s;
      wcnt_d  = load_wcnt_s;
    end else begin
      load_s = 1'b0;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (!hresetn_i) begin
      state_q <= TGT_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= {(BB+AW){1'b0}};
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (load_s) begin
        addr_q  <= haddr_i[BB+AW-1:0];
        write_q <= hwrite_i;
        size_q  <= hsize_i;
      end
    end
  end

  // reset on the completing edge must drop the pending write
  always_comb begin
    if (done_s && write_q && hresetn_i) begin
      we_s = lane_mask(addr_q[BB-1:0], size_q);
    end else begin
      we_s = {NB{1'b0}};
    end
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    hrdata_o    = {DATA_WIDTH{1'b0}};
    case (state_q)
      TGT_IDLE: hreadyout_o = 1'b1;
      TGT_WAIT: begin
        hreadyout_o = done_s;
        if (done_s && !write_q) begin
          hrdata_o = rdata_s;
        end else begin
          hrdata_o = {DATA_WIDTH{1'b0}};
        end
      end
      TGT_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      TGT_ERR2: hresp_o = HRESP_ERROR;
      default:  hreadyout_o = 1'b1;
    endcase
  end

  adbg_ahb3_tgt_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk_i  (hclk_i),
    .we_i   (we_s),
    .addr_i (addr_q[BB+AW-1:BB]),
    .wdata_i(hwdata_i),
    .rdata_o(rdata_s)
  );

endmodule
